// File: rtl/tube_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tube_pkg
//  Description : Shared constants for the single-clock Tube register block:
//                flag bit positions, register addresses, error-vector layout
//                and the value returned by a read of an empty FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package tube_pkg;

    // Flag register bit positions (S is the set/clear selector, not stored)
    localparam int c_flag_q = 0;
    localparam int c_flag_i = 1;
    localparam int c_flag_j = 2;
    localparam int c_flag_m = 3;
    localparam int c_flag_v = 4;
    localparam int c_flag_p = 5;
    localparam int c_flag_t = 6;
    localparam int c_flag_s = 7;

    // Register map: even addresses are status, odd addresses are data
    localparam logic [2:0] c_addr_stat1 = 3'd0;
    localparam logic [2:0] c_addr_data1 = 3'd1;
    localparam logic [2:0] c_addr_stat2 = 3'd2;
    localparam logic [2:0] c_addr_data2 = 3'd3;
    localparam logic [2:0] c_addr_stat3 = 3'd4;
    localparam logic [2:0] c_addr_data3 = 3'd5;
    localparam logic [2:0] c_addr_stat4 = 3'd6;
    localparam logic [2:0] c_addr_data4 = 3'd7;

    // Error vector: host-side errors in the low nibble, parasite-side above
    localparam int c_err_host_lsb = 0;
    localparam int c_err_para_lsb = 4;

    // Data returned when popping an empty FIFO
    localparam logic [7:0] c_rd_empty = 8'hFF;

    // Clamp an occupancy to the six status bits
    function automatic logic [5:0] sat6(input int unsigned v);
        return (v > 32'd63) ? 6'h3F : v[5:0];
    endfunction

endpackage : tube_pkg
`default_nettype wire

// File: rtl/tube_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tube_sync_fifo
//  Description : Circular-buffer byte FIFO with registered occupancy count,
//                synchronous clear and a run-time capacity limit. Pointers
//                wrap at DEPTH, so non-power-of-two depths are supported.
//  Revision    : 1.0 - initial release
// ============================================================================
module tube_sync_fifo #(
    parameter  int DEPTH = 1,
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             clr,
    input  logic [CW-1:0]    cap,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr;
    logic [PW-1:0]    r_rd;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Full compares against the live capacity, so shrinking the capacity
    // below the stored occupancy keeps the data and simply blocks writes.
    assign empty     = (r_count == '0);
    assign full      = (r_count >= cap);
    assign count     = r_count;
    assign dout      = r_mem[r_rd];
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Pointer and occupancy state; clear empties the FIFO and overrides traffic
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (clr) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wr <= next_ptr(r_wr);
            if (w_do_pop)  r_rd <= next_ptr(r_rd);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents are don't-care while the count says empty
    always_ff @(posedge clk) begin
        if (w_do_push && !clr) r_mem[r_wr] <= din;
    end

endmodule : tube_sync_fifo
`default_nettype wire

// File: rtl/tube_sync.sv
`default_nettype none
// ============================================================================
//  Module      : tube_sync
//  Description : Single-clock Tube register block. Host and parasite buses,
//                each qualified by its own cycle enable on the common phi2,
//                exchange bytes through four bidirectional FIFO channels.
//                Adds occupancy readback and sticky overflow/underflow flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module tube_sync
    import tube_pkg::*;
#(
    parameter int R1_PH_DEPTH = 24,
    parameter int DEPTH       = 1,
    parameter int R3_DEPTH    = 2,
    parameter int COUNT_EN    = 1
) (
    input  logic       phi2,
    input  logic       rst_b,
    input  logic       h_en,
    input  logic       h_cs_b,
    input  logic [2:0] h_addr,
    input  logic       h_rdnw,
    input  logic [7:0] h_data_in,
    output logic [7:0] h_data_out,
    output logic       h_irq_b,
    input  logic       p_en,
    input  logic       p_cs_b,
    input  logic [2:0] p_addr,
    input  logic       p_rdnw,
    input  logic [7:0] p_data_in,
    output logic [7:0] p_data_out,
    output logic       p_rst_b,
    output logic       p_nmi_b,
    output logic       p_irq_b,
    output logic [7:0] err
);

    logic       w_h_acc, w_p_acc;
    logic [1:0] w_h_ch, w_p_ch;
    logic [3:0] w_h_push, w_h_pop, w_p_push, w_p_pop;
    logic [3:0] w_ph_empty, w_ph_full, w_hp_empty, w_hp_full;
    logic [7:0] w_ph_dout [4];
    logic [7:0] w_hp_dout [4];
    logic [5:0] w_ph_occ  [4];
    logic [5:0] w_hp_occ  [4];
    logic [7:0] w_err_set;
    logic       w_flag_wr, w_soft, w_n_term;
    logic [6:0] r_flags;
    logic [5:0] r_pflags;
    logic [7:0] r_err;

    assign w_h_acc = h_en & ~h_cs_b;
    assign w_p_acc = p_en & ~p_cs_b;
    assign w_h_ch  = h_addr[2:1];
    assign w_p_ch  = p_addr[2:1];

    // Only the host may write the flags; parasite writes to addr 0 are dropped
    assign w_flag_wr = w_h_acc & ~h_rdnw & (h_addr == c_addr_stat1);

    // Soft reset also fires on the write that sets T so the FIFOs read
    // empty from the very next cycle rather than one cycle later.
    assign w_soft = r_flags[c_flag_t]
                  | (w_flag_wr & h_data_in[c_flag_s] & h_data_in[c_flag_t]);

    // Decode data-register accesses into per-channel push/pop strobes
    always_comb begin
        w_h_push = '0;
        w_h_pop  = '0;
        w_p_push = '0;
        w_p_pop  = '0;
        for (int k = 0; k < 4; k++) begin
            w_h_push[k] = w_h_acc & ~h_rdnw & h_addr[0] & (w_h_ch == 2'(k));
            w_h_pop[k]  = w_h_acc &  h_rdnw & h_addr[0] & (w_h_ch == 2'(k));
            w_p_push[k] = w_p_acc & ~p_rdnw & p_addr[0] & (w_p_ch == 2'(k));
            w_p_pop[k]  = w_p_acc &  p_rdnw & p_addr[0] & (w_p_ch == 2'(k));
        end
    end

    // One FIFO per direction per channel; channel 3 capacity follows V
    for (genvar k = 0; k < 4; k++) begin : g_ch
        localparam int PH_D  = (k == 0) ? R1_PH_DEPTH : ((k == 2) ? R3_DEPTH : DEPTH);
        localparam int HP_D  = (k == 2) ? R3_DEPTH : DEPTH;
        localparam int PH_CW = $clog2(PH_D + 1);
        localparam int HP_CW = $clog2(HP_D + 1);

        logic [PH_CW-1:0] ph_cap, ph_cnt;
        logic [HP_CW-1:0] hp_cap, hp_cnt;

        if (k == 2) begin : g_vmode
            assign ph_cap = r_flags[c_flag_v] ? PH_CW'(R3_DEPTH) : PH_CW'(1);
            assign hp_cap = r_flags[c_flag_v] ? HP_CW'(R3_DEPTH) : HP_CW'(1);
        end else begin : g_fixed
            assign ph_cap = PH_CW'(PH_D);
            assign hp_cap = HP_CW'(HP_D);
        end

        tube_sync_fifo #(.DEPTH(PH_D), .WIDTH(8)) u_ph (
            .clk   (phi2),
            .rst_b (rst_b),
            .clr   (w_soft),
            .cap   (ph_cap),
            .push  (w_p_push[k]),
            .pop   (w_h_pop[k]),
            .din   (p_data_in),
            .dout  (w_ph_dout[k]),
            .empty (w_ph_empty[k]),
            .full  (w_ph_full[k]),
            .count (ph_cnt)
        );

        tube_sync_fifo #(.DEPTH(HP_D), .WIDTH(8)) u_hp (
            .clk   (phi2),
            .rst_b (rst_b),
            .clr   (w_soft),
            .cap   (hp_cap),
            .push  (w_h_push[k]),
            .pop   (w_p_pop[k]),
            .din   (h_data_in),
            .dout  (w_hp_dout[k]),
            .empty (w_hp_empty[k]),
            .full  (w_hp_full[k]),
            .count (hp_cnt)
        );

        assign w_ph_occ[k] = sat6(32'(ph_cnt));
        assign w_hp_occ[k] = sat6(32'(hp_cnt));
    end

    // Overflow (push when full) and underflow (pop when empty) per side
    always_comb begin
        w_err_set = '0;
        for (int k = 0; k < 4; k++) begin
            w_err_set[c_err_host_lsb + k] = (w_h_push[k] & w_hp_full[k])
                                          | (w_h_pop[k]  & w_ph_empty[k]);
            w_err_set[c_err_para_lsb + k] = (w_p_push[k] & w_ph_full[k])
                                          | (w_p_pop[k]  & w_hp_empty[k]);
        end
    end

    // Flag register, delayed parasite copy and sticky error vector
    always_ff @(posedge phi2 or negedge rst_b) begin
        if (!rst_b) begin
            r_flags  <= '0;
            r_pflags <= '0;
            r_err    <= '0;
        end else begin
            if (w_flag_wr) begin
                for (int n = 0; n < 7; n++) begin
                    if (h_data_in[n]) r_flags[n] <= h_data_in[c_flag_s];
                end
            end
            r_pflags <= r_flags[5:0];
            r_err    <= w_soft ? 8'h00 : (r_err | w_err_set);
        end
    end

    // Channel 3 parasite "attention" term shared by NMI and addr-4 status
    assign w_n_term = w_ph_empty[2]
                    | (w_hp_occ[2] >= (r_flags[c_flag_v] ? 6'd2 : 6'd1));

    // Host read mux: data pops the inbound FIFO, status reports its state
    always_comb begin
        h_data_out = c_rd_empty;
        if (h_addr[0]) begin
            h_data_out = w_ph_empty[w_h_ch] ? c_rd_empty : w_ph_dout[w_h_ch];
        end else begin
            h_data_out[7] = ~w_ph_empty[w_h_ch];
            h_data_out[6] = ~w_hp_full[w_h_ch];
            if (w_h_ch == 2'd0)
                h_data_out[5:0] = r_flags[5:0];
            else
                h_data_out[5:0] = (COUNT_EN != 0) ? w_ph_occ[w_h_ch] : 6'h3F;
        end
    end

    // Parasite read mux; flags come from the one-cycle-delayed copy
    always_comb begin
        p_data_out = c_rd_empty;
        if (p_addr[0]) begin
            p_data_out = w_hp_empty[w_p_ch] ? c_rd_empty : w_hp_dout[w_p_ch];
        end else begin
            p_data_out[7] = (w_p_ch == 2'd2) ? w_n_term : ~w_hp_empty[w_p_ch];
            p_data_out[6] = ~w_ph_full[w_p_ch];
            if (w_p_ch == 2'd0)
                p_data_out[5:0] = r_pflags;
            else
                p_data_out[5:0] = (COUNT_EN != 0) ? w_hp_occ[w_p_ch] : 6'h3F;
        end
    end

    assign h_irq_b = ~(r_flags[c_flag_q] & ~w_ph_empty[3]);
    assign p_irq_b = ~((r_flags[c_flag_i] & ~w_hp_empty[0])
                     | (r_flags[c_flag_j] & ~w_hp_empty[3]));
    assign p_nmi_b = ~(r_flags[c_flag_m] & w_n_term);
    assign p_rst_b = ~r_flags[c_flag_p] & rst_b;
    assign err     = r_err;

endmodule : tube_sync
`default_nettype wire

// File: tb/tb_tube_sync.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tube_sync
//  Description : Directed self-checking bench for tube_sync with default
//                parameters. Expected FIFO data is queued when written and
//                compared when read back.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tube_sync;

    logic       phi2 = 1'b0;
    logic       rst_b = 1'b0;
    logic       h_en, h_cs_b, h_rdnw, p_en, p_cs_b, p_rdnw;
    logic [2:0] h_addr, p_addr;
    logic [7:0] h_data_in, p_data_in, h_data_out, p_data_out, err;
    logic       h_irq_b, p_rst_b, p_nmi_b, p_irq_b;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] hq, pq, exp_v;
    logic [7:0] q_ph1 [$];
    logic [7:0] q_hp3 [$];

    tube_sync dut (
        .phi2       (phi2),
        .rst_b      (rst_b),
        .h_en       (h_en),
        .h_cs_b     (h_cs_b),
        .h_addr     (h_addr),
        .h_rdnw     (h_rdnw),
        .h_data_in  (h_data_in),
        .h_data_out (h_data_out),
        .h_irq_b    (h_irq_b),
        .p_en       (p_en),
        .p_cs_b     (p_cs_b),
        .p_addr     (p_addr),
        .p_rdnw     (p_rdnw),
        .p_data_in  (p_data_in),
        .p_data_out (p_data_out),
        .p_rst_b    (p_rst_b),
        .p_nmi_b    (p_nmi_b),
        .p_irq_b    (p_irq_b),
        .err        (err)
    );

    // Free-running phi2
    always #5 phi2 = ~phi2;

    // Hard stop if the sequence ever stalls
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One bus cycle on either or both sides; read data captured mid-cycle
    task automatic cycle(input logic hs, input logic [2:0] ha, input logic hrnw,
                         input logic [7:0] hd, input logic ps, input logic [2:0] pa,
                         input logic prnw, input logic [7:0] pd);
        @(negedge phi2);
        h_en = hs; h_cs_b = ~hs; h_addr = ha; h_rdnw = hrnw; h_data_in = hd;
        p_en = ps; p_cs_b = ~ps; p_addr = pa; p_rdnw = prnw; p_data_in = pd;
        #1;
        hq = h_data_out;
        pq = p_data_out;
        @(posedge phi2);
        #1;
        h_en = 1'b0; h_cs_b = 1'b1; p_en = 1'b0; p_cs_b = 1'b1;
    endtask

    task automatic hw(input logic [2:0] a, input logic [7:0] d); cycle(1'b1, a, 1'b0, d, 1'b0, 3'd0, 1'b1, 8'h00); endtask
    task automatic hr(input logic [2:0] a);                      cycle(1'b1, a, 1'b1, 8'h00, 1'b0, 3'd0, 1'b1, 8'h00); endtask
    task automatic pw(input logic [2:0] a, input logic [7:0] d); cycle(1'b0, 3'd0, 1'b1, 8'h00, 1'b1, a, 1'b0, d); endtask
    task automatic pr(input logic [2:0] a);                      cycle(1'b0, 3'd0, 1'b1, 8'h00, 1'b1, a, 1'b1, 8'h00); endtask

    initial begin
        h_en = 1'b0; h_cs_b = 1'b1; h_addr = 3'd0; h_rdnw = 1'b1; h_data_in = 8'h00;
        p_en = 1'b0; p_cs_b = 1'b1; p_addr = 3'd0; p_rdnw = 1'b1; p_data_in = 8'h00;

        // Reset state
        repeat (2) @(negedge phi2);
        #1;
        chk("rst_h_stat0", h_data_out, 8'h40);
        chk("rst_p_rst_b", {7'd0, p_rst_b}, 8'h00);
        chk("rst_irqs", {5'd0, h_irq_b, p_irq_b, p_nmi_b}, 8'h07);
        chk("rst_err", err, 8'h00);
        @(negedge phi2);
        rst_b = 1'b1;
        #1;
        chk("rel_p_rst_b", {7'd0, p_rst_b}, 8'h01);

        // P flag drives parasite reset
        hw(3'd0, 8'hA0);
        chk("p_set_rst", {7'd0, p_rst_b}, 8'h00);
        hw(3'd0, 8'h20);
        chk("p_clr_rst", {7'd0, p_rst_b}, 8'h01);

        // Channel 1 P->H fill to 24, overflow, drain, underflow
        for (int i = 0; i < 24; i++) begin
            pw(3'd1, 8'(i));
            q_ph1.push_back(8'(i));
        end
        hr(3'd0);
        chk("h_stat1_full", hq, 8'hC0);
        pr(3'd0);
        chk("p_stat1_full", pq, 8'h00);
        pw(3'd1, 8'h99);
        chk("err_p_ovf", err, 8'h10);
        for (int i = 0; i < 24; i++) begin
            hr(3'd1);
            exp_v = q_ph1.pop_front();
            chk("ch1_pop", hq, exp_v);
        end
        hr(3'd1);
        chk("ch1_empty_rd", hq, 8'hFF);
        chk("err_h_unf", err, 8'h11);

        // Channel 2 occupancy readback
        pw(3'd3, 8'h55);
        hr(3'd2);
        chk("h_stat2_occ", hq, 8'hC1);
        hr(3'd3);
        chk("ch2_pop", hq, 8'h55);
        pr(3'd2);
        chk("p_stat2", pq, 8'h40);

        // NMI with V=0
        hw(3'd0, 8'h88);
        chk("nmi_m_empty", {7'd0, p_nmi_b}, 8'h00);
        pw(3'd5, 8'h33);
        chk("nmi_ph_data", {7'd0, p_nmi_b}, 8'h01);
        hr(3'd5);
        chk("ch3_ph_pop", hq, 8'h33);
        chk("nmi_ph_drain", {7'd0, p_nmi_b}, 8'h00);

        // NMI with V=1: H->P threshold is 2
        hw(3'd0, 8'h90);
        pw(3'd5, 8'h44);
        chk("nmi_v1_ph", {7'd0, p_nmi_b}, 8'h01);
        hw(3'd5, 8'hA1); q_hp3.push_back(8'hA1);
        chk("nmi_v1_hp1", {7'd0, p_nmi_b}, 8'h01);
        pr(3'd4);
        chk("p_stat3_hp1", pq, 8'h41);
        hw(3'd5, 8'hA2); q_hp3.push_back(8'hA2);
        chk("nmi_v1_hp2", {7'd0, p_nmi_b}, 8'h00);
        pr(3'd4);
        chk("p_stat3_hp2", pq, 8'hC2);
        pr(3'd5);
        exp_v = q_hp3.pop_front();
        chk("ch3_hp_pop", pq, exp_v);
        chk("nmi_v1_back", {7'd0, p_nmi_b}, 8'h01);
        cycle(1'b1, 3'd5, 1'b0, 8'hA3, 1'b1, 3'd5, 1'b1, 8'h00);
        exp_v = q_hp3.pop_front();
        q_hp3.push_back(8'hA3);
        chk("ch3_simul_pop", pq, exp_v);
        pr(3'd4);
        chk("p_stat3_simul", pq, 8'h41);

        // Interrupts, then load every FIFO
        hw(3'd0, 8'h81);
        pw(3'd7, 8'h77);
        chk("h_irq_q", {7'd0, h_irq_b}, 8'h00);
        pw(3'd1, 8'h01);
        pw(3'd3, 8'h02);
        hw(3'd1, 8'h03);
        hw(3'd3, 8'h04);
        hw(3'd7, 8'h05);
        hw(3'd0, 8'h82);
        chk("p_irq_i", {7'd0, p_irq_b}, 8'h00);

        // Soft reset empties FIFOs and clears err, flags survive
        hw(3'd0, 8'hC0);
        q_ph1.delete();
        q_hp3.delete();
        chk("soft_err", err, 8'h00);
        chk("soft_irqs", {6'd0, h_irq_b, p_irq_b}, 8'h03);
        hr(3'd0);
        chk("soft_h_stat1", hq, 8'h5B);
        for (int a = 2; a < 8; a += 2) begin
            hr(3'(a));
            chk("soft_h_avail", hq & 8'h80, 8'h00);
        end
        pr(3'd0); chk("soft_p_stat1", pq & 8'h80, 8'h00);
        pr(3'd2); chk("soft_p_stat2", pq & 8'h80, 8'h00);
        pr(3'd6); chk("soft_p_stat4", pq & 8'h80, 8'h00);
        pr(3'd5); chk("soft_ch3_empty", pq, 8'hFF);

        hw(3'd0, 8'h40);
        hr(3'd0);
        chk("flags_kept", hq, 8'h5B);
        chk("err_after_t", err, 8'h00);
        pw(3'd1, 8'h5A); q_ph1.push_back(8'h5A);
        hr(3'd1);
        exp_v = q_ph1.pop_front();
        chk("ch1_after_t", hq, exp_v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_tube_sync
`default_nettype wire
